chip8_subroutine_ctrl: RTL

//  Sequences CHIP-8 CALL (2NNN) and RET (00EE) for the CPU FSM. Drives the 16-entry

---
 rtl/chip8_subroutine_ctrl_pkg.sv | 35 +++
 rtl/chip8_subroutine_ctrl.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/chip8_subroutine_ctrl_pkg.sv
// Shared definitions for the CHIP-8 subroutine controller.
// Holds the stack operation encoding, the controller state encoding,
// the fault codes reported with done, and the CALL/RET opcode patterns.
package chip8_subroutine_ctrl_pkg;

  // Operation code driven to the return-address stack block.
  typedef enum logic [1:0] {
    STACK_HOLD = 2'b00,
    STACK_PUSH = 2'b01,
    STACK_POP  = 2'b10
  } stack_op_e;

  typedef enum logic [2:0] {
    SUB_IDLE,
    SUB_PUSH,
    SUB_POP,
    SUB_WAIT,
    SUB_CAP,
    SUB_FIN
  } sub_state_e;

  localparam logic [1:0] FAULT_OK  = 2'b00;
  localparam logic [1:0] FAULT_OVF = 2'b01;
  localparam logic [1:0] FAULT_UNF = 2'b10;
  localparam logic [1:0] FAULT_ILL = 2'b11;

  localparam logic [15:0] OPC_RET      = 16'h00EE;
  localparam logic [3:0]  OPC_CALL_NIB = 4'h2;

  localparam int SUB_DEPTH       = 16;
  localparam int SUB_PUSH_CYCLES = 2;
  localparam int SUB_POP_CYCLES  = 2;
  localparam int SUB_RD_WAIT     = 1;

endpackage

// File: rtl/chip8_subroutine_ctrl.sv
// CHIP-8 CALL (2NNN) / RET (00EE) sequencer.
// Accepts a one-cycle start from the CPU FSM, drives the return-address
// stack (push pc+2 on call, pop on return), tracks stack depth and hands
// the next PC back with a one-cycle done pulse plus a fault code.
// Ports:
//   cpu_clk, reset        clock, synchronous active-high reset
//   start, opcode, pc     request and the instruction it refers to
//   busy, done, pc_load   handshake back to the CPU
//   new_pc, fault, depth  result, fault code (valid with done), stack depth
//   stack_op, stack_wdata command and write data to the stack block
//   stack_rdata           popped data from the stack block
module chip8_subroutine_ctrl
  import chip8_subroutine_ctrl_pkg::*;
#(
  parameter int DEPTH       = SUB_DEPTH,
  parameter int PUSH_CYCLES = SUB_PUSH_CYCLES,
  parameter int POP_CYCLES  = SUB_POP_CYCLES,
  parameter int RD_WAIT     = SUB_RD_WAIT
) (
  input  logic        cpu_clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] opcode,
  input  logic [15:0] pc,
  output logic        busy,
  output logic        done,
  output logic        pc_load,
  output logic [15:0] new_pc,
  output logic [1:0]  fault,
  output logic [4:0]  depth,
  output logic [1:0]  stack_op,
  output logic [15:0] stack_wdata,
  input  logic [15:0] stack_rdata
);

  localparam int CNT_W = 4;

  sub_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [11:0]      nnn_q, nnn_d;
  logic [4:0]       depth_q, depth_d;
  logic [15:0]      new_pc_q, new_pc_d;
  logic [15:0]      wdata_q, wdata_d;
  stack_op_e        op_q, op_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pc_load_q, pc_load_d;
  logic [1:0]       fault_q, fault_d;

  // Every output is the registered image of a next-state value, so the
  // combinational block decides outputs for the state being entered.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    nnn_d     = nnn_q;
    depth_d   = depth_q;
    new_pc_d  = new_pc_q;
    wdata_d   = wdata_q;
    op_d      = STACK_HOLD;
    done_d    = 1'b0;
    pc_load_d = 1'b0;
    fault_d   = FAULT_OK;

    unique case (state_q)
      SUB_IDLE: begin
        if (start) begin
          nnn_d = opcode[11:0];
          if (opcode[15:12] == OPC_CALL_NIB) begin
            if (depth_q == 5'(DEPTH)) begin
              state_d = SUB_FIN;
              done_d  = 1'b1;
              fault_d = FAULT_OVF;
            end else begin
              state_d = SUB_PUSH;
              cnt_d   = '0;
              op_d    = STACK_PUSH;
              wdata_d = pc + 16'd2;
            end
          end else if (opcode == OPC_RET) begin
            if (depth_q == 5'd0) begin
              state_d = SUB_FIN;
              done_d  = 1'b1;
              fault_d = FAULT_UNF;
            end else begin
              state_d = SUB_POP;
              cnt_d   = '0;
              op_d    = STACK_POP;
            end
          end else begin
            state_d = SUB_FIN;
            done_d  = 1'b1;
            fault_d = FAULT_ILL;
          end
        end
      end
      SUB_PUSH: begin
        if (cnt_q == CNT_W'(PUSH_CYCLES - 1)) begin
          state_d   = SUB_FIN;
          depth_d   = depth_q + 5'd1;
          new_pc_d  = {4'h0, nnn_q};
          done_d    = 1'b1;
          pc_load_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
          op_d  = STACK_PUSH;
        end
      end
      SUB_POP: begin
        if (cnt_q == CNT_W'(POP_CYCLES - 1)) begin
          state_d = SUB_WAIT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
          op_d  = STACK_POP;
        end
      end
      SUB_WAIT: begin
        // Give the stack block time to present the popped entry.
        if (cnt_q == CNT_W'(RD_WAIT - 1)) begin
          state_d = SUB_CAP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      SUB_CAP: begin
        state_d   = SUB_FIN;
        new_pc_d  = stack_rdata;
        depth_d   = depth_q - 5'd1;
        done_d    = 1'b1;
        pc_load_d = 1'b1;
      end
      SUB_FIN: begin
        state_d = SUB_IDLE;
      end
      default: begin
        state_d = SUB_IDLE;
      end
    endcase

    busy_d = (state_d != SUB_IDLE);
  end

  always_ff @(posedge cpu_clk) begin
    if (reset) begin
      state_q   <= SUB_IDLE;
      cnt_q     <= '0;
      nnn_q     <= '0;
      depth_q   <= '0;
      new_pc_q  <= '0;
      wdata_q   <= '0;
      op_q      <= STACK_HOLD;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pc_load_q <= 1'b0;
      fault_q   <= FAULT_OK;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      nnn_q     <= nnn_d;
      depth_q   <= depth_d;
      new_pc_q  <= new_pc_d;
      wdata_q   <= wdata_d;
      op_q      <= op_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pc_load_q <= pc_load_d;
      fault_q   <= fault_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign pc_load     = pc_load_q;
  assign new_pc      = new_pc_q;
  assign fault       = fault_q;
  assign depth       = depth_q;
  assign stack_op    = op_q;
  assign stack_wdata = wdata_q;

endmodule
